// File: rtl/mem_sized_lsu.sv
// Big-endian byte-addressed data memory with sized loads/stores and programmable wait states.
// Define MEM_ERR_EN to reject reserved-size, misaligned and out-of-range requests.
module mem_sized_lsu #(
    parameter int unsigned MEM_DEPTH   = 250000,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err
);
    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned EXT_W = ADDR_W + 2;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t            state, state_next;
    logic [7:0]        cnt;
    logic              rw_q;
    logic [1:0]        size_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic [7:0]        mem [MEM_DEPTH];

    logic              accept;
    logic              commit;
    logic [2:0]        nbytes;
    logic [EXT_W-1:0]  byte_addr [4];
    logic [3:0]        lane_used;
    logic [3:0]        lane_in_range;
    logic [3:0]        lane_we;
    logic [7:0]        lane_wbyte [4];
    logic [7:0]        lane_rbyte [4];
    logic [31:0]       raw;
    logic [31:0]       rdata_c;
    logic              err_c;

    assign accept = (state == ST_IDLE) && req_valid;
    assign commit = (state == ST_WAIT) && (cnt == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (req_valid)  state_next = ST_WAIT;
            ST_WAIT: if (cnt == '0)  state_next = ST_RESP;
            ST_RESP:                 state_next = ST_IDLE;
            default:                 state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Reserved size 11 behaves as a word when error checking is disabled.
    always_comb begin
        unique case (size_q)
            2'b00:   nbytes = 3'd1;
            2'b01:   nbytes = 3'd2;
            default: nbytes = 3'd4;
        endcase
    end

    // Lane i covers byte A+i; it maps to the (nbytes-1-i)th byte of the right-justified word.
    always_comb begin
        raw = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            byte_addr[i]     = {2'b00, addr_q} + EXT_W'(i);
            lane_used[i]     = (i < 32'(nbytes));
            lane_in_range[i] = (byte_addr[i] < EXT_W'(MEM_DEPTH));
            lane_wbyte[i]    = '0;
            lane_rbyte[i]    = '0;
            if (lane_used[i]) begin
                lane_wbyte[i] = wdata_q[8*(32'(nbytes)-1-i) +: 8];
                if (lane_in_range[i]) lane_rbyte[i] = mem[byte_addr[i][IDX_W-1:0]];
                raw[8*(32'(nbytes)-1-i) +: 8] = lane_rbyte[i];
            end
        end
    end

    always_comb begin
        unique case (size_q)
            2'b00:   rdata_c = {{24{signed_q & raw[7]}},  raw[7:0]};
            2'b01:   rdata_c = {{16{signed_q & raw[15]}}, raw[15:0]};
            default: rdata_c = raw;
        endcase
    end

`ifdef MEM_ERR_EN
    logic [EXT_W-1:0] last_addr;
    assign last_addr = {2'b00, addr_q} + EXT_W'(nbytes) - EXT_W'(1);
    assign err_c = (size_q == 2'b11)
                || ((size_q == 2'b01) && addr_q[0])
                || ((size_q == 2'b10) && (addr_q[1:0] != 2'b00))
                || (last_addr >= EXT_W'(MEM_DEPTH));
`else
    assign err_c = 1'b0;
`endif

    assign lane_we = (commit && !rw_q && !err_c) ? (lane_used & lane_in_range) : 4'b0000;

    // Array has no reset: contents survive reset, only commit edges write.
    always_ff @(posedge clock) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (lane_we[i]) mem[byte_addr[i][IDX_W-1:0]] <= lane_wbyte[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            rw_q     <= 1'b0;
            size_q   <= '0;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                cnt      <= 8'(WAIT_CYCLES);
                rw_q     <= req_rw;
                size_q   <= req_size;
                signed_q <= req_signed;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
            end else if ((state == ST_WAIT) && (cnt != '0)) begin
                cnt <= cnt - 8'd1;
            end
            if (commit) begin
                err_q   <= err_c;
                rdata_q <= (rw_q && !err_c) ? rdata_c : '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_sized_lsu.sv
// Scoreboard bench for mem_sized_lsu: one instance with no wait states, one with three.
// Expectations follow the MEM_ERR_EN setting of the build.
module tb_mem_sized_lsu;
    localparam int unsigned DEPTH = 256;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        rv  [2];
    logic        rdy [2];
    logic        rw  [2];
    logic [1:0]  sz  [2];
    logic        sg  [2];
    logic [31:0] ad  [2];
    logic [31:0] wd  [2];
    logic        vld [2];
    logic [31:0] rd  [2];
    logic        er  [2];

    int   vectors    = 0;
    int   miscompares = 0;
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t m0, m1;

    always #5 clock = ~clock;

    mem_sized_lsu #(.MEM_DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(0)) u_dut0 (
        .clock(clock), .reset(reset),
        .req_valid(rv[0]), .req_ready(rdy[0]), .req_rw(rw[0]), .req_size(sz[0]),
        .req_signed(sg[0]), .req_addr(ad[0]), .req_wdata(wd[0]),
        .resp_valid(vld[0]), .resp_rdata(rd[0]), .resp_err(er[0])
    );

    mem_sized_lsu #(.MEM_DEPTH(DEPTH), .ADDR_W(32), .WAIT_CYCLES(3)) u_dut3 (
        .clock(clock), .reset(reset),
        .req_valid(rv[1]), .req_ready(rdy[1]), .req_rw(rw[1]), .req_size(sz[1]),
        .req_signed(sg[1]), .req_addr(ad[1]), .req_wdata(wd[1]),
        .resp_valid(vld[1]), .resp_rdata(rd[1]), .resp_err(er[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Monitor: every response is matched against the oldest queued expectation.
    always @(negedge clock) begin
        if (vld[0]) begin
            if (q0.size() == 0) chk("dut0 unexpected response", 32'd1, 32'd0);
            else begin
                m0 = q0.pop_front();
                chk({m0.name, " rdata"}, rd[0], m0.rdata);
                chk({m0.name, " err"}, 32'(er[0]), 32'(m0.err));
            end
        end
        if (vld[1]) begin
            if (q1.size() == 0) chk("dut3 unexpected response", 32'd1, 32'd0);
            else begin
                m1 = q1.pop_front();
                chk({m1.name, " rdata"}, rd[1], m1.rdata);
                chk({m1.name, " err"}, 32'(er[1]), 32'(m1.err));
            end
        end
    end

    task automatic issue(input int d, input string name, input logic r, input logic [1:0] s,
                         input logic sgn, input logic [31:0] a, input logic [31:0] w,
                         input logic [31:0] exp_rd, input logic exp_err, input logic hold);
        int   k;
        int   lat_exp;
        exp_t e;
        lat_exp = (d == 0) ? 2 : 5;
        @(negedge clock);
        k = 0;
        while (!rdy[d] && k < 20) begin
            @(negedge clock);
            k++;
        end
        chk({name, " ready"}, 32'(rdy[d]), 32'd1);
        rv[d] = 1'b1; rw[d] = r; sz[d] = s; sg[d] = sgn; ad[d] = a; wd[d] = w;
        e.rdata = exp_rd; e.err = exp_err; e.name = name;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        @(posedge clock);
        #1;
        if (!hold) rv[d] = 1'b0;
        else begin
            rw[d] = ~r; sz[d] = s ^ 2'b11; sg[d] = ~sgn; ad[d] = a + 32'd4; wd[d] = ~w;
        end
        k = 0;
        while (1) begin
            @(negedge clock);
            k++;
            if (hold) chk({name, " busy"}, 32'(rdy[d]), 32'd0);
            if (vld[d] || k >= 20) break;
        end
        rv[d] = 1'b0;
        chk({name, " latency"}, k, lat_exp);
        if (hold) begin
            @(negedge clock);
            chk({name, " single pulse"}, 32'(vld[d]), 32'd0);
            chk({name, " ready after"}, 32'(rdy[d]), 32'd1);
        end
    endtask

    task automatic wr(input int d, input string name, input logic [1:0] s, input logic [31:0] a,
                      input logic [31:0] w, input logic exp_err);
        issue(d, name, 1'b0, s, 1'b0, a, w, 32'd0, exp_err, 1'b0);
    endtask

    task automatic rdq(input int d, input string name, input logic [1:0] s, input logic sgn,
                       input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_err);
        issue(d, name, 1'b1, s, sgn, a, 32'd0, exp_rd, exp_err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int pulses;
        for (int d = 0; d < 2; d++) begin
            rv[d] = 1'b0; rw[d] = 1'b0; sz[d] = '0; sg[d] = 1'b0; ad[d] = '0; wd[d] = '0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        for (int d = 0; d < 2; d++) begin
            chk("reset req_ready", 32'(rdy[d]), 32'd1);
            chk("reset resp_valid", 32'(vld[d]), 32'd0);
            chk("reset resp_rdata", rd[d], 32'd0);
            chk("reset resp_err", 32'(er[d]), 32'd0);
        end
        reset = 1'b0;

        wr (0, "w word 0x10", 2'b10, 32'h10, 32'h11223344, 1'b0);
        rdq(0, "r byte u 0x11", 2'b00, 1'b0, 32'h11, 32'h00000022, 1'b0);
        @(negedge clock);
        chk("rdata held after resp", rd[0], 32'h00000022);

        wr (0, "w byte 0x20", 2'b00, 32'h20, 32'h00000080, 1'b0);
        rdq(0, "r byte s 0x20", 2'b00, 1'b1, 32'h20, 32'hFFFFFF80, 1'b0);
        rdq(0, "r byte u 0x20", 2'b00, 1'b0, 32'h20, 32'h00000080, 1'b0);
        wr (0, "w word 0x24", 2'b10, 32'h24, 32'h8899AABB, 1'b0);
        rdq(0, "r half s 0x24", 2'b01, 1'b1, 32'h24, 32'hFFFF8899, 1'b0);
        rdq(0, "r half u 0x26", 2'b01, 1'b0, 32'h26, 32'h0000AABB, 1'b0);
        rdq(0, "r byte s 0x27", 2'b00, 1'b1, 32'h27, 32'hFFFFFFBB, 1'b0);

        wr (0, "w word 0x30", 2'b10, 32'h30, 32'h00000000, 1'b0);
        wr (0, "w half 0x30", 2'b01, 32'h30, 32'h1234BEEF, 1'b0);
        rdq(0, "r word 0x30", 2'b10, 1'b0, 32'h30, 32'hBEEF0000, 1'b0);
        wr (0, "w byte 0x33", 2'b00, 32'h33, 32'hFFFFFF5A, 1'b0);
        rdq(0, "r word 0x30 b", 2'b10, 1'b0, 32'h30, 32'hBEEF005A, 1'b0);

`ifdef MEM_ERR_EN
        wr (0, "w word misaligned 0x13", 2'b10, 32'h13, 32'hDEADBEEF, 1'b1);
        rdq(0, "r word 0x10 intact", 2'b10, 1'b0, 32'h10, 32'h11223344, 1'b0);
        rdq(0, "r word oob", 2'b10, 1'b0, DEPTH - 2, 32'h0, 1'b1);
        wr (0, "w word last", 2'b10, DEPTH - 4, 32'hCAFEF00D, 1'b0);
        rdq(0, "r word last", 2'b10, 1'b0, DEPTH - 4, 32'hCAFEF00D, 1'b0);
        rdq(0, "r half last", 2'b01, 1'b0, DEPTH - 2, 32'h0000F00D, 1'b0);
        rdq(0, "r size11", 2'b11, 1'b0, 32'h10, 32'h0, 1'b1);
        rdq(0, "r half misaligned", 2'b01, 1'b1, 32'h11, 32'h0, 1'b1);
`else
        wr (0, "w word misaligned 0x13", 2'b10, 32'h13, 32'hDEADBEEF, 1'b0);
        rdq(0, "r word 0x10 merged", 2'b10, 1'b0, 32'h10, 32'h112233DE, 1'b0);
        rdq(0, "r word misaligned 0x13", 2'b10, 1'b0, 32'h13, 32'hDEADBEEF, 1'b0);
        rdq(0, "r size11 as word", 2'b11, 1'b0, 32'h10, 32'h112233DE, 1'b0);
        wr (0, "w word last", 2'b10, DEPTH - 4, 32'hCAFEF00D, 1'b0);
        rdq(0, "r word partly oob", 2'b10, 1'b0, DEPTH - 2, 32'hF00D0000, 1'b0);
        wr (0, "w word partly oob", 2'b10, DEPTH - 2, 32'h01020304, 1'b0);
        rdq(0, "r word last b", 2'b10, 1'b0, DEPTH - 4, 32'hCAFE0102, 1'b0);
        rdq(0, "r half straddle", 2'b01, 1'b0, DEPTH - 1, 32'h00000200, 1'b0);
`endif

        wr   (1, "ws3 word 0x40", 2'b10, 32'h40, 32'h01020304, 1'b0);
        issue(1, "ws3 r word held", 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 32'h01020304, 1'b0, 1'b1);

        // Write aborted by reset while waiting: no response, memory keeps old word.
        @(negedge clock);
        chk("abort ready before", 32'(rdy[1]), 32'd1);
        rv[1] = 1'b1; rw[1] = 1'b0; sz[1] = 2'b10; ad[1] = 32'h40; wd[1] = 32'hAABBCCDD;
        @(posedge clock);
        #1 rv[1] = 1'b0;
        @(negedge clock);
        chk("abort in wait", 32'(rdy[1]), 32'd0);
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clock);
        chk("abort ready after reset", 32'(rdy[1]), 32'd1);
        pulses = 0;
        repeat (6) begin
            @(negedge clock);
            if (vld[1]) pulses++;
        end
        chk("abort no response", pulses, 32'd0);
        rdq(1, "ws3 r word after abort", 2'b10, 1'b0, 32'h40, 32'h01020304, 1'b0);

        repeat (3) @(negedge clock);
        chk("dut0 scoreboard drained", q0.size(), 32'd0);
        chk("dut3 scoreboard drained", q1.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
